// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two requesters,
// with a registered single-entry result slot that can drain and refill in the same cycle.
module alu_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d, rsp_id_q, rsp_id_d, rsp_zero_q, rsp_zero_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d, a, b, alu;
  logic [2:0]       op;
  logic             sel, slot_free, accept;
  // When both are valid the requester that did not win last time goes next.
  always_comb begin
    sel = (req0_valid && req1_valid) ? !last_grant_q : req1_valid;
    slot_free = state_q == EMPTY || rsp_ready;
    accept = slot_free && (req0_valid || req1_valid);
    a = sel ? req1_a : req0_a;
    b = sel ? req1_b : req0_b;
    op = sel ? req1_op : req0_op;
    alu = op == 3'b001 ? a - b :
          op == 3'b010 ? a & b :
          op == 3'b011 ? a | b :
          op == 3'b101 ? {{(WIDTH-1){1'b0}}, a < b} : a + b;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      last_grant_q <= 1'b1;
      rsp_id_q <= 1'b0;
      rsp_zero_q <= 1'b0;
      rsp_result_q <= '0;
    end else begin
      state_q <= state_d;
      last_grant_q <= last_grant_d;
      rsp_id_q <= rsp_id_d;
      rsp_zero_q <= rsp_zero_d;
      rsp_result_q <= rsp_result_d;
    end
  end
  always_comb begin
    state_d = accept ? FULL : rsp_ready ? EMPTY : state_q;
    last_grant_d = accept ? sel : last_grant_q;
    rsp_id_d = accept ? sel : rsp_id_q;
    rsp_result_d = accept ? alu : rsp_result_q;
    rsp_zero_d = accept ? alu == '0 : rsp_zero_q;
  end
  always_comb begin
    req0_ready = slot_free && req0_valid && !sel;
    req1_ready = slot_free && req1_valid && sel;
    rsp_valid = state_q == FULL;
    rsp_id = rsp_id_q;
    rsp_result = rsp_result_q;
    rsp_zero = rsp_zero_q;
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks against a transaction-level arbiter/ALU model.
module tb_alu_arbiter;
  localparam int W = 16;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req0_valid, req0_ready, req1_valid, req1_ready, rsp_valid, rsp_ready, rsp_id, rsp_zero;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b, rsp_result;
  logic [2:0] req0_op, req1_op;
  int errors = 0, checks = 0;
  int g, lg;
  logic exp_valid, exp_id, exp_zero;
  logic [W-1:0] exp_res;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_zero(rsp_zero)
  );

  function automatic logic [W-1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    longint x = longint'(a), y = longint'(b), m = 64'd1 << W;
    case (op)
      3'd1: return W'((x + m - y) % m);
      3'd2: return a & b;
      3'd3: return a | b;
      3'd5: return (x < y) ? W'(1) : W'(0);
      default: return W'((x + y) % m);
    endcase
  endfunction

  task automatic model_reset();
    exp_valid = 1'b0; exp_id = 1'b0; exp_res = '0; exp_zero = 1'b0; lg = 1;
  endtask

  task automatic set_in(input logic v0, input logic [W-1:0] a0, input logic [W-1:0] b0, input logic [2:0] op0,
                        input logic v1, input logic [W-1:0] a1, input logic [W-1:0] b1, input logic [2:0] op1,
                        input logic rr);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
    rsp_ready = rr;
    if (!rst_n || (exp_valid && !rr)) g = -1;
    else if (v0 && v1) g = 1 - lg;
    else g = v0 ? 0 : v1 ? 1 : -1;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (g == 0) begin
      exp_valid = 1'b1; exp_id = 1'b0; exp_res = ref_alu(req0_a, req0_b, req0_op); lg = 0;
    end else if (g == 1) begin
      exp_valid = 1'b1; exp_id = 1'b1; exp_res = ref_alu(req1_a, req1_b, req1_op); lg = 1;
    end else if (rsp_ready) exp_valid = 1'b0;
    exp_zero = exp_res == '0;
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    set_in(0, '0, '0, 3'd0, 0, '0, '0, 3'd0, 1);
    checks++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_zero, req0_ready, req1_ready} !== '0) begin
      errors++;
      $display("FAIL reset_state: got valid=%b id=%b res=%h zero=%b rdy=%b%b want all 0",
               rsp_valid, rsp_id, rsp_result, rsp_zero, req0_ready, req1_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    set_in(0, '0, '0, 3'd0, 0, '0, '0, 3'd0, 1);
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got rdy=%b%b valid=%b want 00 0", req0_ready, req1_ready, rsp_valid);
    end
  endtask

  task automatic test_contention();
    for (int i = 0; i < 4; i++) begin
      set_in(1, W'($urandom), W'($urandom), 3'($urandom), 1, W'($urandom), W'($urandom), 3'($urandom), 1);
      checks++;
      if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
        errors++;
        $display("FAIL contention_grant[%0d]: got rdy=%b%b want rdy0=%b", i, req0_ready, req1_ready, i % 2 == 0);
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'(i % 2) || rsp_result !== exp_res || rsp_zero !== exp_zero) begin
        errors++;
        $display("FAIL contention_rsp[%0d]: got v=%b id=%b res=%h z=%b want v=1 id=%0d res=%h z=%b",
                 i, rsp_valid, rsp_id, rsp_result, rsp_zero, i % 2, exp_res, exp_zero);
      end
    end
  endtask

  task automatic test_alu();
    logic [W+W+W+4:0] vec [11] = '{
      {1'b0, 16'h0005, 16'h0003, 3'd0, 16'h0008}, {1'b0, 16'hFFFF, 16'h0001, 3'd0, 16'h0000},
      {1'b1, 16'h0007, 16'h0007, 3'd1, 16'h0000}, {1'b1, 16'h00F0, 16'h0FF0, 3'd2, 16'h00F0},
      {1'b1, 16'h00F0, 16'h0F00, 3'd3, 16'h0FF0}, {1'b1, 16'h0002, 16'h0002, 3'd6, 16'h0004},
      {1'b0, 16'h0003, 16'h0009, 3'd5, 16'h0001}, {1'b0, 16'h0009, 16'h0003, 3'd5, 16'h0000},
      {1'b0, 16'hFFFF, 16'h0001, 3'd5, 16'h0000}, {1'b1, 16'h0005, 16'h0007, 3'd4, 16'h000C},
      {1'b1, 16'h0005, 16'h0007, 3'd7, 16'h000C}};
    for (int i = 0; i < 11; i++) begin
      logic id;
      logic [W-1:0] a, b, want;
      logic [2:0] op;
      {id, a, b, op, want} = vec[i];
      set_in(!id, a, b, op, id, a, b, op, 1);
      checks++;
      if (req0_ready !== !id || req1_ready !== id) begin
        errors++;
        $display("FAIL alu_ready[%0d]: got rdy=%b%b want id %b", i, req0_ready, req1_ready, id);
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== id || rsp_result !== want || rsp_zero !== (want == '0)
          || rsp_result !== exp_res) begin
        errors++;
        $display("FAIL alu_rsp[%0d] op=%0d: got v=%b id=%b res=%h z=%b want v=1 id=%b res=%h z=%b",
                 i, op, rsp_valid, rsp_id, rsp_result, rsp_zero, id, want, want == '0);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held;
    set_in(0, '0, '0, 3'd0, 0, '0, '0, 3'd0, 1);
    tick();
    set_in(1, 16'h1234, 16'h0101, 3'd1, 0, '0, '0, 3'd0, 1);
    tick();
    held = exp_res;
    for (int i = 0; i < 3; i++) begin
      set_in(1, W'($urandom), W'($urandom), 3'd0, 1, 16'h0030, 16'h0005, 3'd0, 0);
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_id !== 1'b0
          || rsp_result !== 16'h1133 || held !== 16'h1133) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: got rdy=%b%b v=%b id=%b res=%h want 00 1 0 1133",
                 i, req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result);
      end
      tick();
    end
    set_in(1, W'($urandom), W'($urandom), 3'd0, 1, 16'h0030, 16'h0005, 3'd0, 1);
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release: got rdy=%b%b want 01", req0_ready, req1_ready);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== 16'h0035) begin
      errors++;
      $display("FAIL backpressure_rsp: got v=%b id=%b res=%h want 1 1 0035", rsp_valid, rsp_id, rsp_result);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      set_in(1'($urandom), W'($urandom_range(0, 3) == 0 ? 0 : $urandom), W'($urandom), 3'($urandom),
             1'($urandom), W'($urandom), W'($urandom_range(0, 3) == 0 ? 0 : $urandom), 3'($urandom),
             $urandom_range(0, 9) < 7);
      checks++;
      if (req0_ready !== (g == 0) || req1_ready !== (g == 1)) begin
        errors++;
        $display("FAIL random_ready[%0d]: got rdy=%b%b want grant %0d", i, req0_ready, req1_ready, g);
      end
      tick();
      checks++;
      if (rsp_valid !== exp_valid
          || (exp_valid && (rsp_id !== exp_id || rsp_result !== exp_res || rsp_zero !== exp_zero))) begin
        errors++;
        $display("FAIL random_rsp[%0d]: got v=%b id=%b res=%h z=%b want v=%b id=%b res=%h z=%b",
                 i, rsp_valid, rsp_id, rsp_result, rsp_zero, exp_valid, exp_id, exp_res, exp_zero);
      end
    end
  endtask

  task automatic test_reset_full();
    set_in(1, 16'h0005, 16'h0003, 3'd0, 1, 16'h0009, 16'h0001, 3'd0, 1);
    tick();
    set_in(0, '0, '0, 3'd0, 1, 16'h0009, 16'h0001, 3'd0, 0);
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result === '0) begin
      errors++;
      $display("FAIL reset_full_setup: got v=%b res=%h want v=1 nonzero", rsp_valid, rsp_result);
    end
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_zero} !== '0) begin
      errors++;
      $display("FAIL reset_full_async: got v=%b id=%b res=%h z=%b want all 0", rsp_valid, rsp_id, rsp_result, rsp_zero);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    set_in(1, 16'h0004, 16'h0004, 3'd1, 1, 16'h0009, 16'h0001, 3'd0, 0);
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_full_first_grant: got rdy=%b%b want 10", req0_ready, req1_ready);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 16'h0000 || rsp_zero !== 1'b1) begin
      errors++;
      $display("FAIL reset_full_rsp: got v=%b id=%b res=%h z=%b want 1 0 0000 1", rsp_valid, rsp_id, rsp_result, rsp_zero);
    end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_alu();
    test_backpressure();
    test_random();
    test_reset_full();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester round-robin arbiter that shares one combinational ALU between independent clients, such as the execute stage and a multi-cycle address/branch helper. Each requester presents operands and an ALU opcode with a valid/ready handshake. The block computes the selected operation and returns a registered result with a zero flag and requester ID through a single-entry output slot with backpressure. It sits between the requesters and the ALU and is the only driver of the ALU inputs.

## Interface
- WIDTH, default 16, operand/result width in bits
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 presents an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a, req0_b  in  WIDTH  requester 0 operands A, B
- req0_op  in  3  requester 0 ALU opcode
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as requester 0, for requester 1
- rsp_valid  out  1  output slot holds a result
- rsp_ready  in  1  consumer takes the result this cycle
- rsp_id  out  1  requester that issued the held result
- rsp_result  out  WIDTH  registered ALU result
- rsp_zero  out  1  1 when rsp_result == 0

## Operation
- Opcodes: 000 add, 001 sub (A−B), 010 bitwise AND, 011 bitwise OR, 101 unsigned set-less-than (result 1 if A<B else 0, zero-extended to WIDTH). All other codes (100, 110, 111) perform add.
- Add and sub wrap modulo 2^WIDTH. There is no carry or overflow output.
- Output-slot FSM:
  - EMPTY (rsp_valid=0): go to FULL on accept.
  - FULL (rsp_valid=1): stay in FULL if rsp_ready and a new accept happen in the same cycle; go to EMPTY if rsp_ready with no accept; otherwise hold.
- slot_free = !rsp_valid || rsp_ready. This is a combinational path from rsp_ready to reqN_ready.
- Arbitration uses the last_grant register:
  - Only one requester valid: that requester is selected.
  - Both valid: the requester != last_grant is selected.
  - reqN_ready = slot_free && reqN_valid && selected(N). At most one ready is high per cycle.
- Accept happens when reqN_valid && reqN_ready. On accept:
  - the selected operands/opcode drive the ALU
  - rsp_result, rsp_zero, rsp_id and last_grant load on the next clock edge
- ALU inputs are driven from the selected requester's operands even when no request is accepted (don't-care). The outputs only load on accept.
- While in FULL without rsp_ready, rsp_result, rsp_zero and rsp_id hold stable, and both readys are 0.
- Requesters may drop valid without a handshake. The arbiter keeps no state about unaccepted requests.

## Timing
- Latency: an operation accepted in cycle N appears with rsp_valid=1 in cycle N+1.
- Throughput: one operation per cycle while rsp_ready stays high (drain and fill in the same cycle).
- Reset values (asynchronous, applied immediately when rst_n falls):
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0
  - last_grant=1, so requester 0 wins the first contested cycle
  - reqN_ready is combinational and low while both requesters are idle
- Reset mid-operation: the held result is discarded with no response. The first cycle after release behaves as EMPTY.
- Simultaneous drain and accept: the new result replaces the old one at the edge. No bubble, no loss.
- Fairness: with both requesters continuously valid and rsp_ready=1, grants strictly alternate. The maximum wait is one accepted operation.

## Test plan
- Add: req0 a=5, b=3, op=000, rsp_ready=1 → req0_ready=1 same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_result=8, rsp_zero=0. Wrap case: 0xFFFF+1 → 0x0000, rsp_zero=1.
- Sub and logic on req1: 7−7 → result 0, rsp_zero=1. 0x00F0 AND 0x0FF0 → 0x00F0. 0x00F0 OR 0x0F00 → 0x0FF0. Opcode 110 with 2,2 → 4.
- SLT: 3<9 → 1, rsp_zero=0. 9<3 → 0, rsp_zero=1. 0xFFFF<1 → 0 (unsigned).
- Contention: both valid for 4 cycles after reset, rsp_ready=1 → grant order 0,1,0,1, one result per cycle with matching rsp_id.
- Backpressure: accept from req0, then rsp_ready=0 for 3 cycles with both valid → result/id stable, both readys 0. Raise rsp_ready → req1 accepted that same cycle, and its result appears next cycle.
- Reset in FULL: pull rst_n low while rsp_valid=1 → rsp_valid, rsp_result, rsp_id go to 0 without waiting for a clock edge. After release, with both valid → req0 granted first.
